// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Bits needed to hold the values 0..n-1 (never less than 1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receive FIFO and the memory stage that drains it.
// Latency: n/a (wires only).
// Backpressure: none; the FIFO drops bytes when full and flags overflow.
// Signals: rx (serial line in), rdreq (pop), empty, q (popped byte),
//          usedw (byte count), overflow (sticky drop flag), frame_err (pulse).
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic                  rx;
  logic                  rdreq;
  logic                  empty;
  logic [7:0]            q;
  logic [DEPTH_LOG2:0]   usedw;
  logic                  overflow;
  logic                  frame_err;

  // FIFO side
  modport slave (
    input  rx, rdreq,
    output empty, q, usedw, overflow, frame_err
  );

  // Memory stage / line driver side
  modport master (
    output rx, rdreq,
    input  empty, q, usedw, overflow, frame_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 2-flop synchronizer plus bit-timing FSM, emits one byte per good frame.
// Latency: byte_vld pulses one cycle after the stop bit is sampled.
// Backpressure: none; the consumer must accept byte_vld on the cycle it is high.
// Ports: clk, rst (sync, active-high), rx (async line), byte_dat/byte_vld (received byte),
//        frame_err (one-cycle pulse when the stop bit is sampled low).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_dat,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int                BAUD_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              vld_q, vld_d;
  logic              ferr_q, ferr_d;
  logic              rx_s1_q, rx_s1_d;
  logic              rx_s2_q, rx_s2_d;
  logic              rx_sync;

  assign rx_sync = rx_s2_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    vld_d     = 1'b0;
    ferr_d    = 1'b0;
    rx_s1_d   = rx;
    rx_s2_d   = rx_s1_q;

    case (state_q)
      ST_IDLE: begin
        baud_d    = '0;
        bit_cnt_d = '0;
        if (!rx_sync) state_d = ST_START;
      end
      // Re-check the start bit near its middle; a high line means it was a glitch.
      ST_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d    = '0;
          shift_d   = {rx_sync, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (rx_sync) begin
            vld_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      // A low stop bit may be a break; do not hunt for a start edge until the line idles.
      ST_WAIT_HIGH: begin
        if (rx_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
    end
  end

  // shift_q is stable while vld_q is high because the FSM sits in IDLE.
  assign byte_dat  = shift_q;
  assign byte_vld  = vld_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a 2**DEPTH_LOG2-byte FIFO popped by the memory stage.
// Latency: q valid one cycle after a pop; empty/usedw update one cycle after push/pop.
// Backpressure: none toward the line; a byte arriving while full is dropped and overflow sticks.
// Ports: clk, rst (sync, active-high), bus (slave modport: rx, rdreq in; empty, q, usedw,
//        overflow, frame_err out).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0] rx_byte_dat;
  logic       rx_byte_vld;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (bus.rx),
    .byte_dat  (rx_byte_dat),
    .byte_vld  (rx_byte_vld),
    .frame_err (bus.frame_err)
  );

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            q_q, q_d;
  logic                  overflow_q, overflow_d;
  logic                  empty, full, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = bus.rdreq && !empty;
  // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign push  = rx_byte_vld && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    q_d        = q_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      q_d      = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (rx_byte_vld && !push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      q_q        <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      q_q        <= q_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset so it maps onto plain RAM; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte_dat;
  end

  assign bus.empty    = empty;
  assign bus.usedw    = count_q;
  assign bus.q        = q_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB = 8;
  localparam int DL2 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         ferr_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    int         exp_usedw;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always @(posedge clk) begin
    if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bit_out(input logic v);
    bus.rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Drive one 8N1 frame from a negedge; rst_bit >= 0 pulses rst at the start of that data bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int rst_bit);
    logic [7:0] dv;
    dv = d;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.rx = dv[i];
      if (i == rst_bit) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (CPB - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    bit_out(stop_ok ? 1'b1 : 1'b0);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_model(input logic [7:0] d);
    send_frame(d, 1'b1, -1);
    if (exp_q.size() < 16) exp_q.push_back(d);
  endtask

  task automatic pop_check(input string name);
    bus.rdreq = 1'b1;
    @(negedge clk);
    bus.rdreq = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: popped 0x%0h with no byte expected", name, bus.q);
    end else begin
      check(name, bus.q, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int got;
    int ferr_base;
    logic [7:0] exp_pop;

    vecs[0] = '{8'h3C, 1'b0, 0, 1};
    vecs[1] = '{8'h11, 1'b1, 1, 1};
    vecs[2] = '{8'h00, 1'b1, 2, 1};
    vecs[3] = '{8'hFF, 1'b1, 3, 1};
    vecs[4] = '{8'h80, 1'b0, 3, 2};
    vecs[5] = '{8'h5A, 1'b1, 4, 2};

    bus.rx    = 1'b1;
    bus.rdreq = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_empty", bus.empty, 1);
    check("rst_usedw", bus.usedw, 0);
    check("rst_q", bus.q, 8'h00);
    check("rst_overflow", bus.overflow, 0);
    check("rst_frame_err", bus.frame_err, 0);

    // Single byte, timing of empty falling
    c = 0;
    fork
      send_model(8'hA5);
      begin
        while (bus.empty && c < 200) begin
          @(negedge clk);
          c++;
        end
      end
    join
    check("a5_empty_fall_window", (c >= 78 && c <= 82), 1);
    check("a5_usedw", bus.usedw, 1);
    pop_check("a5_q");
    check("a5_empty_after", bus.empty, 1);

    // Pop while empty is ignored
    bus.rdreq = 1'b1;
    repeat (2) @(negedge clk);
    bus.rdreq = 1'b0;
    @(negedge clk);
    check("empty_pop_q_hold", bus.q, 8'hA5);
    check("empty_pop_usedw", bus.usedw, 0);

    // Short low glitch
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_usedw", bus.usedw, 0);
    check("glitch_ferr", ferr_cnt, 0);

    // Table: good frames and framing errors
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, vecs[i].stop_ok, -1);
      if (vecs[i].stop_ok) exp_q.push_back(vecs[i].d);
      check($sformatf("vec%0d_usedw", i), bus.usedw, vecs[i].exp_usedw);
      check($sformatf("vec%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
    end
    while (exp_q.size() > 0) pop_check("vec_drain_q");
    check("vec_drain_empty", bus.empty, 1);

    // Overflow: 17 bytes, no reads
    ferr_base = ferr_cnt;
    for (int i = 0; i < 17; i++) send_model(8'(i));
    check("ovf_usedw", bus.usedw, 16);
    check("ovf_flag", bus.overflow, 1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_pop%0d", i));
    check("ovf_empty_after", bus.empty, 1);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_no_ferr", ferr_cnt, ferr_base);

    do_reset();
    check("rst2_overflow", bus.overflow, 0);
    check("rst2_empty", bus.empty, 1);

    // Full + aligned pop with the 17th push
    for (int i = 0; i < 16; i++) send_model(8'(i));
    check("full_usedw", bus.usedw, 16);
    got = 0;
    fork
      send_frame(8'h55, 1'b1, -1);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (dut.rx_byte_vld === 1'b1) begin
            bus.rdreq = 1'b1;
            @(negedge clk);
            bus.rdreq = 1'b0;
            got = 1;
            break;
          end
        end
      end
    join
    exp_pop = exp_q.pop_front();
    exp_q.push_back(8'h55);
    check("align_push_seen", got, 1);
    check("align_q", bus.q, exp_pop);
    check("align_usedw", bus.usedw, 16);
    check("align_overflow", bus.overflow, 0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("align_pop%0d", i));
    check("align_last_q", bus.q, 8'h55);
    check("align_empty_after", bus.empty, 1);

    // Reset mid-frame at data bit 4 of 0xFF
    send_frame(8'hFF, 1'b1, 4);
    exp_q.delete();
    repeat (2 * CPB) @(negedge clk);
    check("midrst_usedw", bus.usedw, 0);
    check("midrst_empty", bus.empty, 1);
    check("midrst_q", bus.q, 8'h00);
    send_model(8'h42);
    check("midrst_next_usedw", bus.usedw, 1);
    pop_check("midrst_next_q");
    check("midrst_next_empty", bus.empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 4, FIFO depth is 2**DEPTH_LOG2 bytes.
REQ-003 Port clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  input  1  reset; the polarity and synchronicity are fixed: synchronous, active-high.
REQ-005 Port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port rdreq  input  1  pop request from the memory stage.
REQ-007 Port empty  output  1  high when the FIFO holds 0 bytes.
REQ-008 Port q  output  8  popped byte; this is the memory stage's uart_in.
REQ-009 Port usedw  output  DEPTH_LOG2+1  current byte count.
REQ-010 Port overflow  output  1  sticky: a received byte was dropped because the FIFO was full.
REQ-011 Port frame_err  output  1  one-cycle pulse: a stop bit sampled low.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; the receiver SHALL use only the synchronized value.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
- IDLE -> START: synchronized rx sampled low.
REQ-014 START SHALL resample the line after CLKS_PER_BIT/2 cycles (integer division).
- Line low: go to DATA.
- Line high: glitch; return to IDLE and push nothing.
REQ-015 DATA SHALL sample 8 bits at intervals of CLKS_PER_BIT cycles and shift them in LSB first, using a 3-bit bit counter.
REQ-016 STOP SHALL sample one bit CLKS_PER_BIT cycles after data bit 7.
- High: issue a push and return to IDLE.
- Low: pulse frame_err for 1 cycle, push nothing, go to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL return to IDLE on the first cycle the synchronized line is high.
REQ-018 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 on every sample.
REQ-019 A push SHALL write the byte at the write pointer and increment it, wrapping modulo 2**DEPTH_LOG2.
REQ-020 A pop SHALL occur when rdreq=1 and empty=0; it SHALL increment the read pointer, wrapping modulo 2**DEPTH_LOG2.
REQ-021 rdreq while empty=1 SHALL be ignored: no pointer change, q unchanged.
REQ-022 q SHALL present the popped byte on the cycle after the pop (registered read latency 1) and SHALL hold that value until the next pop.
- This matches the memory stage, which captures q one cycle after asserting rdreq.
REQ-023 empty and usedw SHALL be registered/derived from registered count only; they SHALL NOT depend combinationally on rdreq or rx.
REQ-024 Push while full:
- With a simultaneous pop: both SHALL occur and usedw SHALL be unchanged.
- Without a pop: the byte SHALL be dropped and overflow SHALL be set.
REQ-025 Push while empty with a simultaneous rdreq: the push SHALL occur and the pop SHALL be ignored; empty SHALL fall on the next cycle.
REQ-026 overflow SHALL clear only on rst.

Reset
REQ-027 On rst=1 the block SHALL enter the following state on the next clk edge:
- FSM = IDLE; pointers, count, usedw, baud counter, bit counter = 0.
- empty=1, q=8'h00, overflow=0, frame_err=0.
- Synchronizer flops = 1.
REQ-028 A frame in progress when rst asserts SHALL be discarded; after rst deasserts, reception SHALL restart only on a fresh falling edge.

Structure
REQ-029 FSM state encodings and the default CLKS_PER_BIT SHALL reside in the shared package uart_pkg, reused by the future TX block.
REQ-030 The receiver (synchronizer + FSM) SHALL be the sub-module uart_rx_core, outputting a byte and a 1-cycle valid; the FIFO SHALL be inline.
REQ-031 FIFO storage SHALL be an inferable register array with no vendor megafunction.

Verification (CLKS_PER_BIT=8 on the bench)
REQ-032 Send 0xA5, then rdreq for 1 cycle: empty falls ~80 cycles after the start edge; q=0xA5 the cycle after rdreq; empty=1 afterwards.
REQ-033 Apply a 3-cycle low glitch on idle rx: no push, usedw=0, frame_err never pulses.
REQ-034 Send 0x3C with the stop bit forced low: frame_err pulses once, usedw=0; a following valid 0x11 is received correctly.
REQ-035 Send 17 bytes 0x00..0x10 with no reads (DEPTH_LOG2=4): usedw=16, overflow=1; sixteen pops return 0x00..0x0F in order.
REQ-036 Fill to 16, then align a pop with the 17th push (0x55): usedw stays 16, overflow=0; the last popped byte is 0x55.
REQ-037 Pulse rst for 1 cycle mid-frame at bit 4 of 0xFF: usedw=0, empty=1, no push of a partial byte; the next full frame 0x42 is received.
